// File: rtl/face_scan_sequencer_if.sv
// Handshake bundle between the cube-scan sequencer and its neighbours:
// the CCD colour sampler, the HW->SW transfer FSM and the operator key/status logic.
interface face_scan_sequencer_if;
  logic       Start;
  logic       Abort;
  logic       Colors_valid;
  logic       Face_done;
  logic       Capture_req;
  logic       ready;
  logic [5:0] FaceNum;
  logic [2:0] Face_idx;
  logic       Busy;
  logic       Scan_done;
  logic       Error;

  // Environment side: drives key, abort and the sampler/transfer pulses.
  modport master (
    output Start, Abort, Colors_valid, Face_done,
    input  Capture_req, ready, FaceNum, Face_idx, Busy, Scan_done, Error
  );

  // Sequencer side.
  modport slave (
    input  Start, Abort, Colors_valid, Face_done,
    output Capture_req, ready, FaceNum, Face_idx, Busy, Scan_done, Error
  );
endinterface

// File: rtl/face_scan_sequencer.sv
// Top-level scheduler for one full cube scan: capture each face, hand it to the
// SW link block, wait for acknowledge, then hold a rotate window before the next face.
// One shared wait counter serves both the capture timeout and the rotate window.
module face_scan_sequencer #(
  parameter int unsigned NUM_FACES      = 6,
  parameter int unsigned ROTATE_CYCLES  = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned CNT_W          = 26
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  face_scan_sequencer_if.slave  bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_HANDOFF = 3'd2;
  localparam logic [2:0] ST_ROTATE  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_ERROR   = 3'd5;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ROTATE_LAST  = CNT_W'(ROTATE_CYCLES - 1);
  localparam logic [2:0]       LAST_FACE    = 3'(NUM_FACES - 1);

  // One-hot face select for a binary face index.
  function automatic logic [5:0] face_onehot(input logic [2:0] idx);
    face_onehot = 6'd1 << idx;
  endfunction

  logic             start_q;
  logic             start_edge_q;
  logic [2:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       idx_q,    idx_d;
  logic             capture_req_q, capture_req_d;
  logic             ready_q,       ready_d;
  logic [5:0]       facenum_q,     facenum_d;
  logic             busy_q,        busy_d;
  logic             scan_done_q,   scan_done_d;
  logic             error_q,       error_d;

  // Next state, wait counter and face index; Abort overrides every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (bus.Abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          // A held key never produces a second edge, so no retrigger here.
          if (start_edge_q) begin
            state_d = ST_CAPTURE;
            cnt_d   = '0;
            idx_d   = 3'd0;
          end else begin
            state_d = state_q;
          end
        end
        ST_CAPTURE: begin
          // Colour data wins over the timeout terminal count in the same cycle.
          if (bus.Colors_valid) begin
            state_d = ST_HANDOFF;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = ST_ERROR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HANDOFF: begin
          // SW pacing is unbounded: no counting while the face is handed off.
          if (bus.Face_done) begin
            cnt_d = '0;
            if (idx_q == LAST_FACE) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ROTATE;
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_ROTATE: begin
          if (cnt_q == ROTATE_LAST) begin
            state_d = ST_CAPTURE;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  // Output values for the state being entered, so outputs switch on the entering edge.
  always_comb begin
    capture_req_d = (state_d == ST_CAPTURE) && (state_q != ST_CAPTURE);
    ready_d       = (state_d == ST_HANDOFF);
    busy_d        = (state_d == ST_CAPTURE) || (state_d == ST_HANDOFF) ||
                    (state_d == ST_ROTATE);
    scan_done_d   = (state_d == ST_DONE);
    error_d       = (state_d == ST_ERROR);
    if (busy_d || scan_done_d) begin
      facenum_d = face_onehot(idx_d);
    end else begin
      facenum_d = 6'd0;
    end
  end

  // State, counter, index, start edge detector and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      start_q       <= 1'b0;
      start_edge_q  <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      capture_req_q <= 1'b0;
      ready_q       <= 1'b0;
      facenum_q     <= 6'd0;
      busy_q        <= 1'b0;
      scan_done_q   <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      start_q       <= bus.Start;
      start_edge_q  <= bus.Start & ~start_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      capture_req_q <= capture_req_d;
      ready_q       <= ready_d;
      facenum_q     <= facenum_d;
      busy_q        <= busy_d;
      scan_done_q   <= scan_done_d;
      error_q       <= error_d;
    end
  end

  assign bus.Capture_req = capture_req_q;
  assign bus.ready       = ready_q;
  assign bus.FaceNum     = facenum_q;
  assign bus.Face_idx    = idx_q;
  assign bus.Busy        = busy_q;
  assign bus.Scan_done   = scan_done_q;
  assign bus.Error       = error_q;

endmodule

// File: tb/tb_face_scan_sequencer.sv
// Directed bench for face_scan_sequencer with a short rotate window (4) and timeout (8).
module tb_face_scan_sequencer;

  logic Clk;
  logic Reset_n;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   cap_cnt = 0;

  logic [5:0] exp_fn [6] = '{6'b000001, 6'b000010, 6'b000100,
                             6'b001000, 6'b010000, 6'b100000};

  face_scan_sequencer_if bus ();

  face_scan_sequencer #(
    .NUM_FACES      (6),
    .ROTATE_CYCLES  (4),
    .TIMEOUT_CYCLES (8),
    .CNT_W          (26)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge; counts capture pulses seen.
  task automatic tick();
    @(posedge Clk);
    #1;
    if (bus.Capture_req === 1'b1) cap_cnt++;
  endtask

  // Raise Start (caller guarantees it was low for at least one edge) and check
  // the two-cycle latency to the first Capture_req.
  task automatic start_scan();
    bus.Start = 1'b1;
    tick();
    chk("start_lat1", 32'(bus.Capture_req), 32'd0);
    tick();
  endtask

  // Enter with the Capture_req edge just passed. mode 0: runs on to the next
  // Capture_req; mode 1: last face, ends in DONE; mode 2: stops one cycle into ROTATE.
  task automatic run_face(input int f, input int mode);
    chk("cap_req",     32'(bus.Capture_req), 32'd1);
    chk("facenum_cap", 32'(bus.FaceNum),     32'(exp_fn[f]));
    chk("face_idx",    32'(bus.Face_idx),    32'(f));
    tick();
    chk("cap_once",    32'(bus.Capture_req), 32'd0);
    tick();
    bus.Colors_valid = 1'b1;
    tick();
    bus.Colors_valid = 1'b0;
    chk("ready_up",    32'(bus.ready),   32'd1);
    chk("facenum_hnd", 32'(bus.FaceNum), 32'(exp_fn[f]));
    repeat (4) tick();
    chk("ready_hold",  32'(bus.ready),   32'd1);
    bus.Face_done = 1'b1;
    tick();
    bus.Face_done = 1'b0;
    chk("ready_dn",    32'(bus.ready),   32'd0);
    chk("facenum_aft", 32'(bus.FaceNum), 32'(exp_fn[f]));
    if (mode == 1) begin
      chk("scan_done", 32'(bus.Scan_done), 32'd1);
      chk("busy_done", 32'(bus.Busy),      32'd0);
    end else begin
      chk("busy_rot",  32'(bus.Busy),      32'd1);
      tick();
      if (mode == 0) begin
        repeat (2) tick();
        chk("rot_wait", 32'(bus.Capture_req), 32'd0);
        tick();
      end
    end
  endtask

  initial begin
    Reset_n          = 1'b0;
    bus.Start        = 1'b0;
    bus.Abort        = 1'b0;
    bus.Colors_valid = 1'b0;
    bus.Face_done    = 1'b0;
    #12;
    chk("rst_cap",     32'(bus.Capture_req), 32'd0);
    chk("rst_ready",   32'(bus.ready),       32'd0);
    chk("rst_facenum", 32'(bus.FaceNum),     32'd0);
    chk("rst_idx",     32'(bus.Face_idx),    32'd0);
    chk("rst_busy",    32'(bus.Busy),        32'd0);
    chk("rst_done",    32'(bus.Scan_done),   32'd0);
    chk("rst_err",     32'(bus.Error),       32'd0);
    Reset_n = 1'b1;
    repeat (2) tick();
    chk("idle_busy", 32'(bus.Busy), 32'd0);

    // T1 + T5: full scan with Start held high throughout.
    cap_cnt = 0;
    start_scan();
    for (int f = 0; f < 6; f++) begin
      run_face(f, (f == 5) ? 1 : 0);
    end
    chk("t1_caps", 32'(cap_cnt), 32'd6);
    repeat (10) tick();
    chk("t5_done_hold", 32'(bus.Scan_done), 32'd1);
    chk("t5_no_retrig", 32'(cap_cnt),       32'd6);
    chk("t5_facenum",   32'(bus.FaceNum),   32'(exp_fn[5]));

    // T2: timeout on face 2.
    bus.Start = 1'b0;
    tick();
    start_scan();
    run_face(0, 0);
    run_face(1, 0);
    chk("t2_cap2", 32'(bus.Capture_req), 32'd1);
    chk("t2_idx2", 32'(bus.Face_idx),    32'd2);
    repeat (7) tick();
    chk("t2_err_early", 32'(bus.Error), 32'd0);
    chk("t2_busy",      32'(bus.Busy),  32'd1);
    tick();
    chk("t2_err",     32'(bus.Error),    32'd1);
    chk("t2_err_idx", 32'(bus.Face_idx), 32'd2);
    chk("t2_err_fn",  32'(bus.FaceNum),  32'd0);
    chk("t2_err_bsy", 32'(bus.Busy),     32'd0);
    bus.Colors_valid = 1'b1;
    tick();
    bus.Colors_valid = 1'b0;
    chk("t2_late_cv",  32'(bus.ready), 32'd0);
    tick();
    chk("t2_err_keep", 32'(bus.Error),    32'd1);
    chk("t2_idx_keep", 32'(bus.Face_idx), 32'd2);
    bus.Start = 1'b0;
    tick();
    start_scan();
    chk("t2_restart",  32'(bus.Capture_req), 32'd1);
    chk("t2_rs_idx",   32'(bus.Face_idx),    32'd0);
    chk("t2_rs_fn",    32'(bus.FaceNum),     32'd1);
    chk("t2_rs_err",   32'(bus.Error),       32'd0);

    // T4: Colors_valid on the timeout terminal cycle.
    repeat (7) tick();
    bus.Colors_valid = 1'b1;
    tick();
    bus.Colors_valid = 1'b0;
    chk("t4_ready", 32'(bus.ready), 32'd1);
    chk("t4_err",   32'(bus.Error), 32'd0);
    bus.Face_done = 1'b1;
    tick();
    bus.Face_done = 1'b0;
    chk("t4_ready_dn", 32'(bus.ready), 32'd0);
    repeat (4) tick();

    // T3: abort during HANDOFF of face 4.
    run_face(1, 0);
    run_face(2, 0);
    run_face(3, 0);
    chk("t3_cap4", 32'(bus.FaceNum), 32'(exp_fn[4]));
    repeat (2) tick();
    bus.Colors_valid = 1'b1;
    tick();
    bus.Colors_valid = 1'b0;
    chk("t3_ready", 32'(bus.ready), 32'd1);
    tick();
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    chk("t3_ab_ready", 32'(bus.ready),    32'd0);
    chk("t3_ab_fn",    32'(bus.FaceNum),  32'd0);
    chk("t3_ab_busy",  32'(bus.Busy),     32'd0);
    chk("t3_ab_idx",   32'(bus.Face_idx), 32'd0);
    bus.Face_done = 1'b1;
    tick();
    bus.Face_done = 1'b0;
    tick();
    chk("t3_fd_ready", 32'(bus.ready),     32'd0);
    chk("t3_fd_busy",  32'(bus.Busy),      32'd0);
    chk("t3_fd_done",  32'(bus.Scan_done), 32'd0);

    // T6: asynchronous reset mid-ROTATE.
    bus.Start = 1'b0;
    tick();
    start_scan();
    run_face(0, 2);
    chk("t6_pre_busy", 32'(bus.Busy), 32'd1);
    bus.Start = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("t6_busy",    32'(bus.Busy),     32'd0);
    chk("t6_facenum", 32'(bus.FaceNum),  32'd0);
    chk("t6_idx",     32'(bus.Face_idx), 32'd0);
    chk("t6_ready",   32'(bus.ready),    32'd0);
    #2;
    Reset_n = 1'b1;
    repeat (6) tick();
    chk("t6_idle_busy", 32'(bus.Busy),        32'd0);
    chk("t6_idle_cap",  32'(bus.Capture_req), 32'd0);
    chk("t6_idle_fn",   32'(bus.FaceNum),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
